mul_iter: RTL and testbench

MUL_ITER -- requirements
Module: mul_iter

---
 rtl/mul_iter_pkg.sv | 24 ++
 rtl/mul_iter_if.sv | 24 ++
 rtl/mul_iter_dp.sv | 86 ++++++++
 rtl/mul_iter.sv | 85 ++++++++
 tb/tb_mul_iter.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/mul_iter_pkg.sv
// mul_iter_pkg -- shared types and constants for the iterative multiplier.
// Holds the controller state encoding and the supported operand width range.
package mul_iter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WIDTH_MIN = 4;
  localparam int WIDTH_MAX = 32;

  // Bits needed to count WIDTH shift-add steps; width is clamped to the
  // supported range so the counter never degenerates.
  function automatic int cnt_width(input int w);
    int c;
    c = w;
    if (c < WIDTH_MIN) c = WIDTH_MIN;
    if (c > WIDTH_MAX) c = WIDTH_MAX;
    return $clog2(c);
  endfunction

endpackage

// File: rtl/mul_iter_if.sv
// mul_iter_if -- request/result bundle between a requester and mul_iter.
// The master drives the operands and op_start; the slave returns busy,
// the finish pulse and the registered product.
interface mul_iter_if #(
  parameter int WIDTH = 16
);
  logic                 op_start;
  logic                 signed_op;
  logic [WIDTH-1:0]     A;
  logic [WIDTH-1:0]     B;
  logic                 busy;
  logic                 mul_finish;
  logic [2*WIDTH-1:0]   Y;

  modport master (
    output op_start, signed_op, A, B,
    input  busy, mul_finish, Y
  );

  modport slave (
    input  op_start, signed_op, A, B,
    output busy, mul_finish, Y
  );
endinterface

// File: rtl/mul_iter_dp.sv
// mul_iter_dp -- radix-2 shift-add datapath for mul_iter.
// Operands are latched on load, one partial product is added per step, and
// the product register is written on the final step.
// Build option: MUL_ITER_SIGNED_EN adds magnitude and negation logic for
// two's-complement operands; without it every multiply is unsigned.
module mul_iter_dp #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 step,
  input  logic                 last,
  input  logic                 signed_op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   y
);

  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] sum_next;

  assign sum_next = acc + (mplier[0] ? mcand : '0);

`ifdef MUL_ITER_SIGNED_EN
  logic neg;

  // Magnitude as a WIDTH-bit unsigned value; the most negative input maps
  // to 2^(WIDTH-1), which still fits.
  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
    return v[WIDTH-1] ? WIDTH'(-v) : WIDTH'(v);
  endfunction

  // Restore the sign of the product; negating zero yields zero.
  function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] p,
                                                     input logic n);
    return n ? -p : p;
  endfunction

  // Operand latch, shift-add step and sign-corrected product load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      neg    <= 1'b0;
      y      <= '0;
    end else if (load) begin
      mcand  <= {{WIDTH{1'b0}}, (signed_op ? magnitude(a) : a)};
      mplier <= signed_op ? magnitude(b) : b;
      neg    <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
      acc    <= '0;
    end else if (step) begin
      acc    <= sum_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      if (last) y <= apply_sign(sum_next, neg);
    end
  end
`else
  logic unused_signed_op;
  assign unused_signed_op = signed_op;

  // Operand latch, shift-add step and product load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      y      <= '0;
    end else if (load) begin
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      acc    <= '0;
    end else if (step) begin
      acc    <= sum_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      if (last) y <= sum_next;
    end
  end
`endif

endmodule

// File: rtl/mul_iter.sv
// mul_iter -- iterative WIDTH x WIDTH multiplier, one shift-add per cycle.
// Controller (IDLE/CALC/DONE FSM and step counter) lives here; arithmetic
// lives in mul_iter_dp.
// Build option: MUL_ITER_SIGNED_EN enables two's-complement operands
// selected by signed_op; otherwise signed_op is ignored.
module mul_iter
  import mul_iter_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic        clk,
  input logic        rst,
  mul_iter_if.slave  bus
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             busy_q;
  logic             finish_q;
  logic             accept;
  logic             step;
  logic             last;

  // A new request is taken whenever no multiply is running, including DONE.
  assign accept = bus.op_start && (state != CALC);
  assign step   = (state == CALC);
  assign last   = step && (cnt == CNT_W'(WIDTH - 1));

  assign bus.busy       = busy_q;
  assign bus.mul_finish = finish_q;

  // Controller FSM with registered busy and finish outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      busy_q   <= 1'b0;
      finish_q <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          finish_q <= 1'b0;
          if (bus.op_start) begin
            state  <= CALC;
            cnt    <= '0;
            busy_q <= 1'b1;
          end else begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        CALC: begin
          cnt <= cnt + CNT_W'(1);
          if (last) begin
            state    <= DONE;
            busy_q   <= 1'b0;
            finish_q <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          busy_q   <= 1'b0;
          finish_q <= 1'b0;
        end
      endcase
    end
  end

  mul_iter_dp #(
    .WIDTH (WIDTH)
  ) u_dp (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .step      (step),
    .last      (last),
    .signed_op (bus.signed_op),
    .a         (bus.A),
    .b         (bus.B),
    .y         (bus.Y)
  );

endmodule

// File: tb/tb_mul_iter.sv
// tb_mul_iter -- bench for mul_iter at WIDTH=16.
// A cycle-level behavioural model predicts busy, mul_finish and Y from the
// arithmetic product and the request timing; directed vectors add literal
// expectations for products, latency and corner cases.
module tb_mul_iter;

  localparam int W = 16;

  logic clk;
  logic rst;

  mul_iter_if #(.WIDTH(W)) bus ();

  mul_iter #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state
  int             calc_left = 0;
  logic [2*W-1:0] pend      = '0;
  logic           exp_busy  = 1'b0;
  logic           exp_fin   = 1'b0;
  logic [2*W-1:0] exp_y     = '0;
  int             cyc       = 0;

  function automatic logic [2*W-1:0] model_prod(input logic [W-1:0] a,
                                                input logic [W-1:0] b,
                                                input logic s);
    longint pa;
    longint pb;
    bit     s_en;
`ifdef MUL_ITER_SIGNED_EN
    s_en = s;
`else
    s_en = s & 1'b0;
`endif
    if (s_en) begin
      pa = longint'($signed(a));
      pb = longint'($signed(b));
    end else begin
      pa = longint'(a);
      pb = longint'(b);
    end
    return (2*W)'(pa * pb);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model update on every edge, then compare DUT outputs just after it.
  task automatic compare_loop();
    bit in_calc;
    forever begin
      @(posedge clk);
      cyc++;
      in_calc = (calc_left > 0);
      if (rst) begin
        calc_left = 0;
        exp_fin   = 1'b0;
        exp_y     = '0;
      end else if (in_calc) begin
        calc_left--;
        if (calc_left == 0) begin
          exp_y   = pend;
          exp_fin = 1'b1;
        end else begin
          exp_fin = 1'b0;
        end
      end else begin
        exp_fin = 1'b0;
        if (bus.op_start) begin
          pend      = model_prod(bus.A, bus.B, bus.signed_op);
          calc_left = W;
        end
      end
      exp_busy = (calc_left > 0);
      #1;
      check("cyc_busy", 64'(bus.busy), 64'(exp_busy));
      check("cyc_finish", 64'(bus.mul_finish), 64'(exp_fin));
      check("cyc_y", 64'(bus.Y), 64'(exp_y));
    end
  endtask

  // One multiply with literal product, latency and busy-length checks.
  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic [2*W-1:0] lit);
    int n;
    int nb;
    bit got;
    @(negedge clk);
    bus.A = a; bus.B = b; bus.signed_op = s; bus.op_start = 1'b1;
    n = 0; nb = 0; got = 1'b0;
    while (!got && n < 100) begin
      @(posedge clk); #1;
      n++;
      bus.op_start = 1'b0;
      if (bus.busy) nb++;
      if (bus.mul_finish) got = 1'b1;
    end
    check({name, "_y"}, 64'(bus.Y), 64'(lit));
    check({name, "_latency"}, 64'(n), 64'(W + 1));
    check({name, "_busy_cycles"}, 64'(nb), 64'(W));
  endtask

  initial begin
    int n;
    int nf;
    bit got;
    logic [2*W-1:0] y_seen;

    rst = 1'b1;
    bus.op_start = 1'b0; bus.signed_op = 1'b0; bus.A = '0; bus.B = '0;
    fork
      compare_loop();
    join_none

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_finish", 64'(bus.mul_finish), 64'd0);
    check("rst_y", 64'(bus.Y), 64'd0);
    @(negedge clk); rst = 1'b0;

    // Unsigned products
    run_op("u_3x5", 16'h0003, 16'h0005, 1'b0, 32'h0000_000F);
    run_op("u_ffff_sq", 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001);
    run_op("u_1234x5678", 16'h1234, 16'h5678, 1'b0, 32'h0626_0060);
    run_op("u_8000_sq", 16'h8000, 16'h8000, 1'b0, 32'h4000_0000);
    run_op("u_zero", 16'h0000, 16'hFFFF, 1'b0, 32'h0000_0000);

    // Y holds while the operand inputs change
    @(negedge clk); bus.A = 16'hABCD; bus.B = 16'h1357;
    repeat (5) @(posedge clk);
    #1;
    check("y_hold", 64'(bus.Y), 64'd0);

`ifdef MUL_ITER_SIGNED_EN
    run_op("s_m1_sq", 16'hFFFF, 16'hFFFF, 1'b1, 32'h0000_0001);
    run_op("s_min_sq", 16'h8000, 16'h8000, 1'b1, 32'h4000_0000);
    run_op("s_min_x1", 16'h8000, 16'h0001, 1'b1, 32'hFFFF_8000);
    run_op("s_m2_x3", 16'hFFFE, 16'h0003, 1'b1, 32'hFFFF_FFFA);
    run_op("s_zero_neg", 16'h0000, 16'hFFFF, 1'b1, 32'h0000_0000);
`else
    run_op("nosign_ffff_x2", 16'hFFFF, 16'h0002, 1'b1, 32'h0001_FFFE);
    run_op("nosign_ffff_sq", 16'hFFFF, 16'hFFFF, 1'b1, 32'hFFFE_0001);
`endif

    // Request during CALC is ignored
    @(negedge clk);
    bus.A = 16'h1234; bus.B = 16'h0010; bus.signed_op = 1'b0; bus.op_start = 1'b1;
    @(posedge clk); #1; bus.op_start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    bus.A = 16'h7777; bus.B = 16'h3333; bus.op_start = 1'b1;
    @(posedge clk); #1; bus.op_start = 1'b0;
    nf = 0; y_seen = '0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.mul_finish) begin nf++; y_seen = bus.Y; end
    end
    check("ignore_y", 64'(y_seen), 64'h0001_2340);
    check("ignore_pulses", 64'(nf), 64'd1);

    // Back-to-back: new request held during the DONE cycle
    @(negedge clk);
    bus.A = 16'h0011; bus.B = 16'h0011; bus.op_start = 1'b1;
    n = 0; got = 1'b0;
    while (!got && n < 100) begin
      @(posedge clk); #1; n++;
      bus.op_start = 1'b0;
      if (bus.mul_finish) got = 1'b1;
    end
    check("b2b_first_y", 64'(bus.Y), 64'h0000_0121);
    bus.A = 16'h0007; bus.B = 16'h0009; bus.op_start = 1'b1;
    n = 0; got = 1'b0;
    while (!got && n < 100) begin
      @(posedge clk); #1; n++;
      bus.op_start = 1'b0;
      if (bus.mul_finish) got = 1'b1;
    end
    check("b2b_second_y", 64'(bus.Y), 64'h0000_003F);
    check("b2b_spacing", 64'(n), 64'd17);

    // Reset in the middle of CALC aborts the multiply
    @(negedge clk);
    bus.A = 16'h0055; bus.B = 16'h0055; bus.op_start = 1'b1;
    @(posedge clk); #1; bus.op_start = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_y", 64'(bus.Y), 64'd0);
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_finish", 64'(bus.mul_finish), 64'd0);
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    nf = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (bus.mul_finish) nf++;
    end
    check("abort_no_finish", 64'(nf), 64'd0);
    run_op("after_rst_2x2", 16'h0002, 16'h0002, 1'b0, 32'h0000_0004);

    repeat (3) @(posedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
